// File: rtl/seg_scan_arbiter_if.sv
// Requester/display bundle for seg_scan_arbiter.
// The brightness input is present only when SEG_SCAN_BRIGHTNESS_EN is defined.
`timescale 1ns/1ps
interface seg_scan_arbiter_if;
    logic        src_sel;
    logic [31:0] a_digits;
    logic [31:0] b_digits;
    logic [3:0]  b_blank_mask;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [2:0]  brightness;
`endif
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        active_src;
    logic        frame_tick;

    modport master (
`ifdef SEG_SCAN_BRIGHTNESS_EN
        output brightness,
`endif
        output src_sel, a_digits, b_digits, b_blank_mask,
        input  an, seg, active_src, frame_tick
    );

    modport slave (
`ifdef SEG_SCAN_BRIGHTNESS_EN
        input  brightness,
`endif
        input  src_sel, a_digits, b_digits, b_blank_mask,
        output an, seg, active_src, frame_tick
    );
endinterface

// File: rtl/seg_scan_arbiter.sv
// 4-digit 7-segment scan controller arbitrating between requesters A and B.
// Optional PWM dimming is enabled by defining SEG_SCAN_BRIGHTNESS_EN.
`timescale 1ns/1ps
module seg_scan_arbiter #(
    parameter int unsigned SCAN_DIV     = 124999,
    parameter int unsigned BLANK_CYCLES = 2000,
    parameter int unsigned DEB_DIV      = 1999999
) (
    input  logic              basys_clock,
    input  logic              reset,
    seg_scan_arbiter_if.slave bus
);
    localparam int unsigned SLOT_W = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam int unsigned DEB_W  = (DEB_DIV > 0) ? $clog2(DEB_DIV + 1) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_DIV);

    typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

    state_t            state;
    logic [SLOT_W-1:0] slot_cnt;
    logic [SLOT_W-1:0] slot_nxt;
    logic [1:0]        idx;
    logic [1:0]        idx_nxt;
    logic [DEB_W-1:0]  deb_cnt;
    logic              sync1;
    logic              sync2;
    logic              deb_sel;
    logic [1:0]        deb_run;
    logic              drive_en;
    logic              slot_wrap;
    logic              src_nxt;
    logic              enter_drive;
    logic              en_nxt;
    logic              pwm_on;
    logic [7:0]        byte_nxt;
    logic [3:0]        an_sel;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [2:0]        pwm_cnt;
`endif

    // Next slot position, digit and source; source may only change on the frame wrap.
    always_comb begin
        slot_wrap   = (slot_cnt == SLOT_LAST);
        slot_nxt    = slot_wrap ? '0 : slot_cnt + 1'b1;
        idx_nxt     = slot_wrap ? idx - 2'd1 : idx;
        src_nxt     = (slot_wrap && (idx == 2'd0)) ? deb_sel : bus.active_src;
        enter_drive = (slot_nxt >= SLOT_BLANK) && ((state == ST_BLANK) || slot_wrap);
        en_nxt      = src_nxt || !bus.b_blank_mask[idx_nxt];
        byte_nxt    = src_nxt ? bus.a_digits[{idx_nxt, 3'b000} +: 8]
                              : bus.b_digits[{idx_nxt, 3'b000} +: 8];
        an_sel      = ~(4'b0001 << idx_nxt);
`ifdef SEG_SCAN_BRIGHTNESS_EN
        pwm_on      = (pwm_cnt <= bus.brightness);
`else
        pwm_on      = 1'b1;
`endif
    end

    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            state          <= ST_BLANK;
            slot_cnt       <= '0;
            idx            <= 2'd3;
            deb_cnt        <= '0;
            sync1          <= 1'b0;
            sync2          <= 1'b0;
            deb_sel        <= 1'b0;
            deb_run        <= 2'd0;
            drive_en       <= 1'b0;
            bus.an         <= 4'hF;
            bus.seg        <= 8'hFF;
            bus.active_src <= 1'b0;
            bus.frame_tick <= 1'b0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
            pwm_cnt        <= 3'd0;
`endif
        end else begin
            slot_cnt       <= slot_nxt;
            idx            <= idx_nxt;
            bus.active_src <= src_nxt;
            bus.frame_tick <= (slot_nxt == SLOT_LAST) && (idx_nxt == 2'd0);

            // Switch debounce: three consecutive differing samples flip the select.
            sync1   <= bus.src_sel;
            sync2   <= sync1;
            deb_cnt <= (deb_cnt == DEB_LAST) ? '0 : deb_cnt + 1'b1;
            if (deb_cnt == DEB_LAST) begin
                if (sync2 != deb_sel) begin
                    if (deb_run == 2'd2) begin
                        deb_sel <= sync2;
                        deb_run <= 2'd0;
                    end else begin
                        deb_run <= deb_run + 2'd1;
                    end
                end else begin
                    deb_run <= 2'd0;
                end
            end

            if (slot_nxt < SLOT_BLANK) begin
                state   <= ST_BLANK;
                bus.an  <= 4'hF;
                bus.seg <= 8'hFF;
            end else begin
                state <= ST_DRIVE;
`ifdef SEG_SCAN_BRIGHTNESS_EN
                pwm_cnt <= pwm_cnt + 3'd1;
`endif
                // Digit byte and mask decision are frozen for the whole drive phase.
                if (enter_drive) begin
                    drive_en <= en_nxt;
                    bus.seg  <= en_nxt ? byte_nxt : 8'hFF;
                    bus.an   <= (en_nxt && pwm_on) ? an_sel : 4'hF;
                end else begin
                    bus.an   <= (drive_en && pwm_on) ? an_sel : 4'hF;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Randomized bench for seg_scan_arbiter against a slot/frame arithmetic model.
// Adds a PWM duty phase when SEG_SCAN_BRIGHTNESS_EN is defined.
`timescale 1ns/1ps
module tb_seg_scan_arbiter;
    localparam int SCAN_DIV     = 19;
    localparam int BLANK_CYCLES = 4;
    localparam int DEB_DIV      = 9;
    localparam int SLOT         = SCAN_DIV + 1;
    localparam int FRAME        = 4 * SLOT;
    localparam int DEB_PER      = DEB_DIV + 1;
    localparam int DRIVE_LEN    = SLOT - BLANK_CYCLES;

    logic basys_clock = 1'b0;
    logic reset;

    seg_scan_arbiter_if bus();

    seg_scan_arbiter #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .DEB_DIV     (DEB_DIV)
    ) dut (
        .basys_clock(basys_clock),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 basys_clock = ~basys_clock;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          t;
    logic        hist[$];
    logic        m_deb;
    int          m_run;
    logic        m_act;
    logic        m_cap_blank;
    logic [7:0]  m_cap_seg;
    int          an_on_cnt;
    logic [2:0]  m_bright = 3'd7;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    // Check cycle t outputs, apply inputs for cycle t, advance the model over the edge.
    task automatic step(input logic sel, input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
        int         pos;
        int         d;
        logic       smp;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        bus.src_sel      = sel;
        bus.a_digits     = a;
        bus.b_digits     = b;
        bus.b_blank_mask = m;
        pos = t % SLOT;
        d   = 3 - ((t / SLOT) % 4);
        if (pos < BLANK_CYCLES || m_cap_blank) begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
        end else begin
            exp_an  = ~(4'b0001 << d);
            exp_seg = m_cap_seg;
        end
`ifdef SEG_SCAN_BRIGHTNESS_EN
        if (m_bright == 3'd7) begin
            check_val("an", bus.an, exp_an);
        end else begin
            check_val("an_pwm_shape", (bus.an == 4'hF) || (bus.an == exp_an), 1);
            if (bus.an != 4'hF) an_on_cnt++;
            if (pos == SLOT - 1) begin
                check_val("pwm_duty", an_on_cnt, m_cap_blank ? 0 : DRIVE_LEN * (m_bright + 1) / 8);
                an_on_cnt = 0;
            end
        end
`else
        check_val("an", bus.an, exp_an);
`endif
        check_val("seg", bus.seg, exp_seg);
        check_val("active_src", bus.active_src, m_act);
        check_val("frame_tick", bus.frame_tick, (t % FRAME) == FRAME - 1);

        hist.push_back(sel);
        if (pos == BLANK_CYCLES - 1) begin
            m_cap_blank = !m_act && m[d];
            m_cap_seg   = m_act ? a[8*d +: 8] : b[8*d +: 8];
        end
        if ((t % FRAME) == FRAME - 1) m_act = m_deb;
        if ((t % DEB_PER) == DEB_PER - 1) begin
            smp = (t >= 2) ? hist[t-2] : 1'b0;
            if (smp != m_deb) begin
                m_run++;
                if (m_run == 3) begin
                    m_deb = smp;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        t++;
        @(posedge basys_clock);
        #1;
    endtask

    // Assert reset mid-cycle, confirm the asynchronous clear, release just after an edge.
    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        check_val("rst_an", bus.an, 4'hF);
        check_val("rst_seg", bus.seg, 8'hFF);
        check_val("rst_active_src", bus.active_src, 0);
        check_val("rst_frame_tick", bus.frame_tick, 0);
        repeat (2) @(posedge basys_clock);
        #1 reset = 1'b0;
        t           = 0;
        hist.delete();
        m_deb       = 1'b0;
        m_run       = 0;
        m_act       = 1'b0;
        m_cap_blank = 1'b1;
        m_cap_seg   = 8'hFF;
        an_on_cnt   = 0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rm;
        logic        rs;
        int          hold;
        reset            = 1'b0;
        t                = 0;
        bus.src_sel      = 1'b0;
        bus.a_digits     = 32'h0;
        bus.b_digits     = 32'h0;
        bus.b_blank_mask = 4'h0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
        bus.brightness   = 3'd7;
`endif
        @(posedge basys_clock);
        #1;
        do_reset();

        // Scan order from reset, then a switch change handed over at the frame boundary.
        for (int i = 0; i < 2 * FRAME; i++)
            step(t >= 10, 32'hA0A1A2A3, 32'h11223344, 4'h0);

        // Short glitch on the switch must not reach the display.
        do_reset();
        for (int i = 0; i < 3 * FRAME; i++)
            step((t >= 20) && (t < 32), 32'hA0A1A2A3, 32'h11223344, 4'h0);

        // Reset in the middle of digit2's drive phase, then restart at digit3.
        do_reset();
        for (int i = 0; i < 30; i++)
            step(1'b0, 32'hA0A1A2A3, 32'h11223344, 4'h0);
        do_reset();
        for (int i = 0; i < FRAME; i++)
            step(1'b0, 32'hA0A1A2A3, 32'h11223344, 4'h0);

        // Blank mask applies to B only.
        do_reset();
        for (int i = 0; i < 2 * FRAME; i++)
            step(1'b0, 32'h5A6B7C8D, 32'h11223344, 4'b1000);
        for (int i = 0; i < 3 * FRAME; i++)
            step(1'b1, 32'h5A6B7C8D, 32'h11223344, 4'b1000);

        // Randomized run: switch held for random spans, data and mask churn mid-slot.
        do_reset();
        ra = $urandom; rb = $urandom; rm = 4'($urandom); rs = 1'b0; hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                rs   = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 50);
            end
            hold--;
            if ($urandom_range(0, 7) == 0) ra = $urandom;
            if ($urandom_range(0, 7) == 0) rb = $urandom;
            if ($urandom_range(0, 31) == 0) rm = 4'($urandom);
            if ($urandom_range(0, 499) == 0) do_reset();
            step(rs, ra, rb, rm);
        end

`ifdef SEG_SCAN_BRIGHTNESS_EN
        // Reduced brightness: anode on for brightness+1 of every 8 drive cycles.
        do_reset();
        m_bright       = 3'd3;
        bus.brightness = 3'd3;
        for (int i = 0; i < 2 * FRAME; i++)
            step(1'b0, 32'hA0A1A2A3, 32'h11223344, 4'b0100);
        m_bright       = 3'd7;
        bus.brightness = 3'd7;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
